// File: rtl/dm_pkg.sv
// Shared types, constants and helpers for the data-memory responder.
package dm_pkg;

  // Responder sequencing: accept, count wait states, present response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  // Wait-state counter width; covers the legal 0..15 range.
  localparam int CNT_W = 4;

  // Replace every byte lane selected by be with the matching lane of wdata.
  function automatic logic [31:0] dm_merge(input logic [31:0] old_word,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word array with synchronous read, byte-lane synchronous write and
// synchronous clear of every word while reset is high.
module dm_ram
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  input  logic [31:0]           trace_pc,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] wr_word;

  // The stored word is the old contents with the enabled lanes replaced.
  assign wr_word = dm_merge(mem_q[addr], wdata, be);
  assign rdata   = rdata_q;

  // Clear on reset; otherwise perform at most one read or write per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_en) mem_q[addr] <= wr_word;
      if (rd_en) rdata_q <= mem_q[addr];
    end
  end

`ifndef SYNTHESIS
  // Store trace: issuing pc, byte address and the merged word.
  always @(posedge clk) begin
    if (!reset && wr_en) begin
      $display("@%h: *%h <= %h", trace_pc, {{(30-ADDR_WIDTH){1'b0}}, addr, 2'b00}, wr_word);
    end
  end
`endif

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder: one load/store per handshake, fixed wait states,
// then a registered response with read data and an error flag.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

  dm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      pc_q, pc_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_load_q, rsp_load_d;

  // Access operands: live request when accessing straight out of IDLE
  // (zero wait states), captured request otherwise.
  logic        acc_fire;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [31:0] acc_pc;
  logic        acc_err;
  logic [31:0] ram_rdata;

  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_be    = (state_q == IDLE) ? req_be    : be_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_pc    = (state_q == IDLE) ? req_pc    : pc_q;
  assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  // Handshake outputs come from state only; read data is the RAM's read
  // register, masked to zero unless the response is a successful load.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_load_q ? ram_rdata : 32'd0;

  // Next-state logic: capture, count down, access, hold until consumed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    pc_d       = pc_q;
    rsp_err_d  = rsp_err_q;
    rsp_load_d = rsp_load_q;
    acc_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          cnt_d   = WAIT_CNT;
          if (WAIT_CNT == '0) begin
            acc_fire = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          acc_fire = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc_fire) begin
      rsp_err_d  = acc_err;
      rsp_load_d = !acc_we && !acc_err;
    end
  end

  // State and payload registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      rsp_err_q  <= rsp_err_d;
      rsp_load_q <= rsp_load_d;
    end
  end

  dm_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (acc_fire && !acc_we && !acc_err),
    .wr_en   (acc_fire && acc_we && !acc_err && (acc_be != 4'b0000)),
    .addr    (acc_addr[ADDR_WIDTH+1:2]),
    .be      (acc_be),
    .wdata   (acc_wdata),
    .trace_pc(acc_pc),
    .rdata   (ram_rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed scenarios plus random
// loads/stores checked against a word-array reference model.
module tb_dm_responder;

  localparam int AW    = 12;
  localparam int WC    = 2;
  localparam int WORDS = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [WORDS];

  dm_responder #(
    .ADDR_WIDTH (AW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_be   (req_be),
    .req_wdata(req_wdata),
    .req_pc   (req_pc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  // Reference behaviour: apply one request to the model and return the
  // response it should produce.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, output logic [31:0] exp_rd,
                              output logic exp_err);
    logic [31:0] mask;
    int          idx;
    exp_err = (addr % 4 != 0) || (addr >= 32'(WORDS * 4));
    exp_rd  = 32'd0;
    if (!exp_err) begin
      idx = int'(addr / 4);
      if (!we) begin
        exp_rd = model[idx];
      end else begin
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        model[idx] = (model[idx] & ~mask) | (wdata & mask);
      end
    end
  endtask

  // Drive one request from a negative edge, wait for its response, hold it
  // for 'hold' extra cycles, then consume it. lat counts negedge samples
  // after the accepting edge until rsp_valid is first seen.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input int hold, input bit intrude,
                        output logic [31:0] rd, output logic err, output int lat,
                        output bit got, output bit stable, output bit blocked,
                        output bit released);
    int g;
    got = 0; lat = 0; stable = 1; blocked = 1; released = 1; rd = '0; err = 1'b0;
    req_we = we; req_addr = addr; req_be = be; req_wdata = wdata; req_pc = $urandom;
    req_valid = 1'b1;
    g = 0;
    while (req_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = i;
        got = 1;
        break;
      end
    end
    if (!got) return;
    rd  = rsp_rdata;
    err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      if (intrude) begin
        req_we = 1'b1; req_addr = 32'h30; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
      end
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== err) stable = 0;
      if (req_ready !== 1'b0) blocked = 0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) released = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; req_pc = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < WORDS; i++) model[i] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  // One request through the driver, compared with the model.
  task automatic check_req(input string name, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
    logic [31:0] rd, exp_rd;
    logic        err, exp_err;
    int          lat;
    bit          got, stable, blocked, released;
    model_access(we, addr, be, wdata, exp_rd, exp_err);
    do_req(we, addr, be, wdata, 0, 1'b0, rd, err, lat, got, stable, blocked, released);
    n_checks++;
    if (!got || lat != WC + 1) begin
      n_fail++;
      $display("FAIL %s_latency: got seen=%0d lat=%0d, want lat=%0d", name, got, lat, WC + 1);
    end
    n_checks++;
    if (rd !== exp_rd || err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_data: addr=%h we=%b be=%b got rdata=%h err=%b, want rdata=%h err=%b",
               name, addr, we, be, rd, err, exp_rd, exp_err);
    end
    n_checks++;
    if (!released) begin
      n_fail++;
      $display("FAIL %s_release: got valid=%b ready=%b after consume, want 0 1", name, rsp_valid, req_ready);
    end
    $display("txn %s: we=%b addr=%h be=%b wdata=%h -> rdata=%h err=%b lat=%0d",
             name, we, addr, be, wdata, rd, err, lat);
  endtask

  task automatic test_directed();
    check_req("load0",        1'b0, 32'h0000_0000, 4'hF, 32'h0);
    check_req("store10",      1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678);
    check_req("load10",       1'b0, 32'h0000_0010, 4'hF, 32'h0);
    check_req("store10_lane1", 1'b1, 32'h0000_0010, 4'b0010, 32'hAABB_CCDD);
    check_req("load10_merged", 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    check_req("load_misalign", 1'b0, 32'h0000_0012, 4'hF, 32'h0);
    check_req("load_range",   1'b0, 32'h0000_4000, 4'hF, 32'h0);
    check_req("store_range",  1'b1, 32'h0000_4000, 4'hF, 32'h5555_AAAA);
    check_req("store_be0",    1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF);
    check_req("load10_after", 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    check_req("load0_alias",  1'b0, 32'h0000_0000, 4'hF, 32'h0);
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, exp_rd;
    logic        err, exp_err;
    int          lat;
    bit          got, stable, blocked, released;
    model_access(1'b0, 32'h10, 4'hF, 32'h0, exp_rd, exp_err);
    do_req(1'b0, 32'h10, 4'hF, 32'h0, 5, 1'b1, rd, err, lat, got, stable, blocked, released);
    n_checks++;
    if (!got || rd !== exp_rd || err !== exp_err) begin
      n_fail++;
      $display("FAIL bp_data: got seen=%0d rdata=%h err=%b, want rdata=%h err=%b", got, rd, err, exp_rd, exp_err);
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_stable: got response changed while held, want stable");
    end
    n_checks++;
    if (!blocked) begin
      n_fail++;
      $display("FAIL bp_ready: got req_ready=1 while response held, want 0");
    end
    n_checks++;
    if (!released) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b ready=%b after consume, want 0 1", rsp_valid, req_ready);
    end
    $display("txn backpressure: hold=5 rdata=%h err=%b stable=%0d blocked=%0d", rd, err, stable, blocked);
    // The store offered during the hold must never have happened.
    check_req("load30_intruder", 1'b0, 32'h0000_0030, 4'hF, 32'h0);
  endtask

  task automatic test_reset_abort();
    bit seen;
    req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'hCAFE_F00D; req_pc = 32'h400;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < WORDS; i++) model[i] = 32'd0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_rsp: got rsp_valid=1 after reset in WAIT, want 0");
    end
    $display("txn reset_abort: store 00000020 aborted, rsp seen=%0d", seen);
    check_req("load20_after_abort", 1'b0, 32'h0000_0020, 4'hF, 32'h0);
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    int          kind;
    for (int n = 0; n < 40; n++) begin
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0)      addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else if (kind == 1) addr = 32'h4000 + 32'($urandom_range(0, 1023) * 4);
      else                addr = 32'($urandom_range(0, 31) * 4);
      check_req("rand", we, addr, be, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
